// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, control-word layout and FSM states for pipe_ctrl_unit.
// Define MULDIV_EN to add multiply/divide decode and the MD_RUN state.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [5:0] FN_SLL     = 6'd0;
   localparam logic [5:0] FN_SRL     = 6'd2;
   localparam logic [5:0] FN_SRA     = 6'd3;
   localparam logic [5:0] FN_JR      = 6'd8;
   localparam logic [5:0] FN_SYSCALL = 6'd12;
   localparam logic [5:0] FN_ADD     = 6'd32;
   localparam logic [5:0] FN_ADDU    = 6'd33;
   localparam logic [5:0] FN_SUB     = 6'd34;
   localparam logic [5:0] FN_AND     = 6'd36;
   localparam logic [5:0] FN_OR      = 6'd37;
   localparam logic [5:0] FN_NOR     = 6'd39;
   localparam logic [5:0] FN_SLT     = 6'd42;
   localparam logic [5:0] FN_SLTU    = 6'd43;
`ifdef MULDIV_EN
   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MULT  = 6'd24;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIV   = 6'd26;
   localparam logic [5:0] FN_DIVU  = 6'd27;
`endif

   localparam int ALU_W = 4;
   localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_SRA  = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0101;
   localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_AND  = 4'b0111;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'b1000;
   localparam logic [ALU_W-1:0] ALU_NOR  = 4'b1010;
   localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1011;
   localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1100;

   localparam int C_BEQ        = 0;
   localparam int C_BNE        = 1;
   localparam int C_MEM_TO_REG = 2;
   localparam int C_MEM_WRITE  = 3;
   localparam int C_ALU_SRC_B  = 4;
   localparam int C_REG_WRITE  = 5;
   localparam int C_REG_DST    = 6;
   localparam int C_SIGNED_EXT = 7;
   localparam int C_JAL        = 8;
   localparam int C_JMP        = 9;
   localparam int C_JR         = 10;
   localparam int C_SYSCALL    = 11;
`ifdef MULDIV_EN
   localparam int C_MD_START   = 12;
   localparam int C_MD_SIGNED  = 13;
   localparam int C_MD_DIV     = 14;
   localparam int C_MFHI       = 15;
   localparam int C_MFLO       = 16;
   localparam int CTRL_W       = 17;
`else
   localparam int CTRL_W       = 12;
`endif

`ifdef MULDIV_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MD_RUN = 2'd1,
      HALTED = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HALTED = 2'd2
   } state_t;
`endif

   function automatic logic [CTRL_W-1:0] cbit(input int idx);
      return CTRL_W'(1) << idx;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID decode: op/func to control word and ALU opcode.
// Multiply/divide funcs decode only when MULDIV_EN is defined.
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(
   parameter int ALU_OP_W = 4
) (
   input  logic [5:0]          op,
   input  logic [5:0]          func,
   output logic [CTRL_W-1:0]   ctrl,
   output logic [ALU_OP_W-1:0] alu_op
);

   logic [ALU_W-1:0] alu;
   logic [CTRL_W-1:0] rr;
   logic [CTRL_W-1:0] imm;

   assign rr  = cbit(C_REG_WRITE) | cbit(C_REG_DST);
   assign imm = cbit(C_ALU_SRC_B) | cbit(C_REG_WRITE);

   always_comb begin
      ctrl = '0;
      alu  = ALU_SLL;
      unique case (op)
         OP_RTYPE: begin
            unique case (func)
               FN_SLL:  begin ctrl = rr; alu = ALU_SLL;  end
               FN_SRL:  begin ctrl = rr; alu = ALU_SRL;  end
               FN_SRA:  begin ctrl = rr; alu = ALU_SRA;  end
               FN_ADD:  begin ctrl = rr; alu = ALU_ADD;  end
               FN_ADDU: begin ctrl = rr; alu = ALU_ADD;  end
               FN_SUB:  begin ctrl = rr; alu = ALU_SUB;  end
               FN_AND:  begin ctrl = rr; alu = ALU_AND;  end
               FN_OR:   begin ctrl = rr; alu = ALU_OR;   end
               FN_NOR:  begin ctrl = rr; alu = ALU_NOR;  end
               FN_SLT:  begin ctrl = rr; alu = ALU_SLT;  end
               FN_SLTU: begin ctrl = rr; alu = ALU_SLTU; end
               FN_JR:      ctrl = cbit(C_JR);
               FN_SYSCALL: ctrl = cbit(C_SYSCALL);
`ifdef MULDIV_EN
               FN_MULT:
                  ctrl = cbit(C_MD_START) | cbit(C_MD_SIGNED);
               FN_MULTU:
                  ctrl = cbit(C_MD_START);
               FN_DIV:
                  ctrl = cbit(C_MD_START) | cbit(C_MD_SIGNED)
                       | cbit(C_MD_DIV);
               FN_DIVU:
                  ctrl = cbit(C_MD_START) | cbit(C_MD_DIV);
               FN_MFHI: ctrl = rr | cbit(C_MFHI);
               FN_MFLO: ctrl = rr | cbit(C_MFLO);
`endif
               default: ctrl = '0;
            endcase
         end
         OP_J:   ctrl = cbit(C_JMP);
         // JAL links into $31, so it writes a register
         OP_JAL: ctrl = cbit(C_JAL) | cbit(C_REG_WRITE);
         OP_BEQ: ctrl = cbit(C_BEQ) | cbit(C_SIGNED_EXT);
         OP_BNE: ctrl = cbit(C_BNE) | cbit(C_SIGNED_EXT);
         OP_ADDI: begin
            ctrl = imm | cbit(C_SIGNED_EXT);
            alu  = ALU_ADD;
         end
         OP_ADDIU: begin
            ctrl = imm | cbit(C_SIGNED_EXT);
            alu  = ALU_ADD;
         end
         OP_SLTI: begin
            ctrl = imm | cbit(C_SIGNED_EXT);
            alu  = ALU_SLT;
         end
         OP_ANDI: begin
            ctrl = imm;
            alu  = ALU_AND;
         end
         OP_ORI: begin
            ctrl = imm;
            alu  = ALU_OR;
         end
         OP_LW: begin
            ctrl = imm | cbit(C_MEM_TO_REG) | cbit(C_SIGNED_EXT);
            alu  = ALU_ADD;
         end
         OP_SW: begin
            ctrl = cbit(C_MEM_WRITE) | cbit(C_ALU_SRC_B)
                 | cbit(C_SIGNED_EXT);
            alu  = ALU_ADD;
         end
         default: begin
            ctrl = '0;
            alu  = ALU_SLL;
         end
      endcase
   end

   assign alu_op = ALU_OP_W'(alu);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID/EX control pipeline register with stall, flush, halt and md FSM.
// MULDIV_EN enables the MD_RUN state and the md_cnt down-counter.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int ALU_OP_W = 4,
   parameter int MD_LAT   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          op,
   input  logic [5:0]          func,
   input  logic                id_valid,
   input  logic                stall_in,
   input  logic                flush,
   output logic [CTRL_W-1:0]   ctrl_ex,
   output logic [ALU_OP_W-1:0] alu_op_ex,
   output logic                ex_valid,
   output logic                stall_out,
   output logic                md_busy,
   output logic                halt
);

   logic [CTRL_W-1:0]   ctrl_id;
   logic [ALU_OP_W-1:0] alu_id;
   logic                md_hazard;
   logic                load;
   logic                load_sys;
   state_t              state;
   state_t              state_nx;

   ctrl_decode #(
      .ALU_OP_W(ALU_OP_W)
   ) u_dec (
      .op    (op),
      .func  (func),
      .ctrl  (ctrl_id),
      .alu_op(alu_id)
   );

   assign stall_out = stall_in | md_hazard | halt;
   assign load      = id_valid & ~flush & ~stall_out;
   assign load_sys  = load & ctrl_id[C_SYSCALL];

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_ex   <= '0;
         alu_op_ex <= '0;
         ex_valid  <= 1'b0;
      end else if (load) begin
         ctrl_ex   <= ctrl_id;
         alu_op_ex <= alu_id;
         ex_valid  <= 1'b1;
      end else begin
         ctrl_ex   <= '0;
         alu_op_ex <= '0;
         ex_valid  <= 1'b0;
      end
   end

`ifdef MULDIV_EN
   localparam int CNT_W = $clog2(MD_LAT);
   localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(MD_LAT - 1);

   logic [CNT_W-1:0] md_cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             sys_pend;
   logic             pend_nx;
   logic             md_class;
   logic             load_md;

   assign md_class = ctrl_id[C_MD_START] | ctrl_id[C_MFHI]
                   | ctrl_id[C_MFLO];
   assign load_md  = load & ctrl_id[C_MD_START];

   // The final busy cycle already lets a dependent op through.
   assign md_hazard = (state == MD_RUN) & (md_cnt != '0)
                    & id_valid & md_class;
   assign md_busy   = (state == MD_RUN);
   assign halt      = (state == HALTED) | sys_pend;

   always_comb begin
      state_nx = state;
      cnt_nx   = md_cnt;
      pend_nx  = sys_pend;
      unique case (state)
         IDLE: begin
            if (load_sys) begin
               state_nx = HALTED;
            end else if (load_md) begin
               state_nx = MD_RUN;
               cnt_nx   = CNT_LD;
            end
         end
         MD_RUN: begin
            if (md_cnt != '0) begin
               cnt_nx = md_cnt - CNT_W'(1);
               if (load_sys) pend_nx = 1'b1;
            end else if (sys_pend | load_sys) begin
               state_nx = HALTED;
               pend_nx  = 1'b0;
            end else if (load_md) begin
               cnt_nx = CNT_LD;
            end else begin
               state_nx = IDLE;
            end
         end
         HALTED: state_nx = HALTED;
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            pend_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         md_cnt   <= '0;
         sys_pend <= 1'b0;
      end else begin
         state    <= state_nx;
         md_cnt   <= cnt_nx;
         sys_pend <= pend_nx;
      end
   end
`else
   assign md_hazard = 1'b0;
   assign md_busy   = 1'b0;
   assign halt      = (state == HALTED);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (load_sys) state_nx = HALTED;
         HALTED:  state_nx = HALTED;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
`endif

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 4, ALU opcode width; legal values are 4 or greater.
REQ-002 SHALL have parameter MD_LAT, default 4, number of EX cycles a multiply/divide occupies; legal values are 2 or greater.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port op, input, 6 bits, opcode of the instruction in ID.
REQ-006 SHALL have port func, input, 6 bits, function field of the instruction in ID.
REQ-007 SHALL have port id_valid, input, 1 bit, ID holds a real instruction.
REQ-008 SHALL have port stall_in, input, 1 bit, external hazard stall.
REQ-009 SHALL have port flush, input, 1 bit, branch/jump kill of the ID instruction.
REQ-010 SHALL have port ctrl_ex, output, CTRL_W bits, registered control word for EX.
REQ-011 SHALL have port alu_op_ex, output, ALU_OP_W bits, registered ALU opcode.
REQ-012 SHALL have port ex_valid, output, 1 bit, EX holds a real instruction.
REQ-013 SHALL have port stall_out, output, 1 bit, combinational: hold PC and IF/ID this cycle.
REQ-014 SHALL have port md_busy, output, 1 bit, a multiply/divide is in progress.
REQ-015 SHALL have port halt, output, 1 bit, a syscall has retired into EX.

Function
REQ-016 SHALL decode the following control fields: beq, bne, mem_to_reg(LW), mem_write(SW), alu_src_b, reg_write, reg_dst, signed_ext, jal, jmp, jr, syscall.
REQ-017 SHALL decode these instructions: SLL/SRA/SRL/ADD/ADDU/SUB/AND/OR/NOR/SLT/SLTU/JR/SYSCALL (op 0; func 0,3,2,32,33,34,36,37,39,42,43,8,12), J(2), JAL(3), BEQ(4), BNE(5), ADDI(8), ADDIU(9), SLTI(10), ANDI(12), ORI(13), LW(35), SW(43).
REQ-018 SHALL encode alu_op as: SLL 0000, SRA 0001, SRL 0010, ADD/ADDU/ADDI/ADDIU/LW/SW 0101, SUB 0110, AND/ANDI 0111, OR/ORI 1000, NOR 1010, SLT/SLTI 1011, SLTU 1100, all other instructions 0000; the encoding is zero-extended to ALU_OP_W.
REQ-019 SHALL decode an unrecognised op/func to an all-zero control word and still mark it valid (treated as a NOP).
REQ-020 SHALL register ctrl_ex, alu_op_ex and ex_valid with 1-cycle latency from the ID inputs.
REQ-021 SHALL assert stall_out = stall_in | md_hazard | halt.
REQ-022 SHALL load a bubble (ex_valid=0, ctrl_ex=0, alu_op_ex=0) into EX when flush=1, when stall_out=1 or when id_valid=0; flush takes priority over stall.
REQ-023 SHALL implement an FSM with states IDLE, MD_RUN and HALTED.
REQ-024 SHALL move IDLE->HALTED when a valid syscall is loaded into EX; HALTED is left only by rst; in HALTED, halt=1 and every EX load is a bubble.
REQ-025 SHALL move IDLE->MD_RUN when a valid mult/div is loaded into EX, loading down-counter md_cnt with MD_LAT-1.
REQ-026 SHALL decrement md_cnt in MD_RUN and move MD_RUN->IDLE when md_cnt=0; md_busy=1 exactly in MD_RUN.
REQ-027 SHALL assert md_hazard while in MD_RUN when id_valid=1 and ID holds MULT/MULTU/DIV/DIVU/MFHI/MFLO; other instructions proceed.
REQ-028 SHALL let a flush in MD_RUN kill only the ID instruction; the running mult/div completes.
REQ-029 SHALL, when a syscall reaches ID in MD_RUN, let it load, enter HALTED after md_cnt reaches 0, and assert halt from the load.

Reset
REQ-030 SHALL, when rst=1, set state=IDLE, md_cnt=0, ctrl_ex=0, alu_op_ex=0, ex_valid=0, md_busy=0 and halt=0; rst overrides every other input.

Configuration
REQ-031 SHALL, with MULDIV_EN defined, decode MULT 24, MULTU 25, DIV 26, DIVU 27, MFHI 16 and MFLO 18; add ctrl fields md_start, md_signed, md_div, mfhi and mflo; and implement MD_RUN.
REQ-032 SHALL, without MULDIV_EN, omit those fields and MD_RUN, treat those funcs as unrecognised, and tie md_busy to 0.

Structure
REQ-033 SHALL place the opcode/func constants, the ALU opcode constants, the ctrl-field index constants, CTRL_W and the state enum in shared package pipe_ctrl_pkg.
REQ-034 SHALL implement decode in a combinational sub-module ctrl_decode (op, func -> ctrl word, alu_op); the pipeline register, FSM and counter live in pipe_ctrl_unit.

Verification
REQ-035 SHALL test: ADD (op 0, func 32), id_valid=1 -> next cycle alu_op_ex=0101, reg_write=1, reg_dst=1, ex_valid=1.
REQ-036 SHALL test: LW then flush=1 with SW -> LW control word, then a bubble (ex_valid=0, mem_write=0).
REQ-037 SHALL test: MULT then MFLO, MD_LAT=4 -> md_busy high 4 cycles, stall_out high 3 cycles, MFLO loads on the cycle md_busy falls.
REQ-038 SHALL test: stall_in=1 and flush=1 on the same cycle -> bubble, stall_out=1, PC held.
REQ-039 SHALL test: SYSCALL then ADDI -> halt=1 from the next cycle, every later ex_valid=0, rst=1 clears halt.
REQ-040 SHALL test: rst=1 mid-MULT -> md_busy=0 and ex_valid=0 the next cycle, state IDLE.
